// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with registered grant, one-cycle bus turnaround and
// optional forced release (BUS_RR_ARBITER_TIMEOUT_EN) after HOLD_MAX cycles.
module bus_rr_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rel,
    input  logic [N*W-1:0] wdat,
    output logic [N-1:0]   gnt,
    output logic [2:0]     owner,
    output logic           busy,
    output logic [W-1:0]   bus_dat,
    output logic           tmo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RECOVER
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_ptr;
    logic [2:0]     r_owner;
    logic [N-1:0]   r_gnt;
    logic [W-1:0]   r_bus_dat;
    logic           r_tmo;

    logic [2*N-1:0] w_req2;
    logic [N-1:0]   w_rot;
    logic           w_found;
    logic [3:0]     w_off;
    logic [3:0]     w_sum;
    logic [2:0]     w_sel;
    logic [2:0]     w_ptr_nxt;
    logic [W-1:0]   w_sel_dat;
    logic [W-1:0]   w_own_dat;
    logic           w_rel_own;
    logic           w_req_own;
    logic           w_normal;
    logic           w_timeout;

    // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
    assign w_req2 = {req, req};
    assign w_rot  = N'(w_req2 >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = 4'(k);
            end
        end
    end

    assign w_sum     = {1'b0, r_ptr} + w_off;
    assign w_sel     = (w_sum >= 4'(N)) ? 3'(w_sum - 4'(N)) : w_sum[2:0];
    assign w_ptr_nxt = (w_sel == 3'(N-1)) ? 3'd0 : w_sel + 3'd1;

    always_comb begin
        w_sel_dat = '0;
        w_own_dat = '0;
        w_rel_own = 1'b0;
        w_req_own = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_sel == 3'(i)) begin
                w_sel_dat = wdat[i*W +: W];
            end
            if (r_owner == 3'(i)) begin
                w_own_dat = wdat[i*W +: W];
                w_rel_own = rel[i];
                w_req_own = req[i];
            end
        end
    end

    assign w_normal = w_rel_own || !w_req_own;

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
    logic [7:0] r_hold;

    assign w_timeout = (r_hold == 8'(HOLD_MAX));

    // Cleared outside GRANT so every grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state != S_GRANT) begin
            r_hold <= '0;
        end else if (!w_timeout) begin
            r_hold <= r_hold + 8'd1;
        end
    end
`else
    logic w_unused_hold;

    assign w_timeout     = 1'b0;
    assign w_unused_hold = (HOLD_MAX > 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (w_normal || w_timeout) begin
                    w_state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_bus_dat <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmo   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner   <= w_sel;
                        r_gnt     <= N'(1) << w_sel;
                        r_ptr     <= w_ptr_nxt;
                        r_bus_dat <= w_sel_dat;
                    end
                end
                S_GRANT: begin
                    if (w_normal || w_timeout) begin
                        r_owner   <= '0;
                        r_gnt     <= '0;
                        r_bus_dat <= '0;
                        r_tmo     <= !w_normal;
                    end else begin
                        r_bus_dat <= w_own_dat;
                    end
                end
                default: begin
                    r_owner   <= '0;
                    r_gnt     <= '0;
                    r_bus_dat <= '0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = (r_state != S_IDLE);
    assign bus_dat = r_bus_dat;
    assign tmo     = r_tmo;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed table, hand sequences and
// random traffic compared against a cycle-level reference model.
module tb_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int HM = 3;
`ifdef BUS_RR_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   rel;
    logic [N*W-1:0] wdat;
    logic [N-1:0]   gnt;
    logic [2:0]     owner;
    logic           busy;
    logic [W-1:0]   bus_dat;
    logic           tmo;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.N(N), .W(W), .HOLD_MAX(HM)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .wdat(wdat),
        .gnt(gnt), .owner(owner), .busy(busy), .bus_dat(bus_dat), .tmo(tmo)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 idle, 1 granted, 2 turnaround.
    int         m_state = 0;
    int         m_owner = 0;
    int         m_ptr   = 0;
    int         m_hold  = 0;
    logic       m_tmo   = 1'b0;
    logic [W-1:0] m_bus = '0;

    function automatic logic [W-1:0] slice(input logic [N*W-1:0] d, input int i);
        return W'(d >> (i * W));
    endfunction

    function automatic void model_step();
        int  cand;
        bit  normal;
        bit  to;
        if (rst) begin
            m_state = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
            m_tmo = 1'b0; m_bus = '0;
            return;
        end
        m_tmo = 1'b0;
        case (m_state)
            0: begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr + k) % N;
                    if (req[cand]) begin
                        m_state = 1; m_owner = cand; m_hold = 0;
                        m_ptr = (cand + 1) % N;
                        m_bus = slice(wdat, cand);
                        break;
                    end
                end
            end
            1: begin
                normal = rel[m_owner] || !req[m_owner];
                to     = TMO_EN && (m_hold == HM);
                if (normal || to) begin
                    m_state = 2; m_tmo = !normal; m_bus = '0;
                end else begin
                    if (m_hold < HM) m_hold++;
                    m_bus = slice(wdat, m_owner);
                end
            end
            default: begin
                m_state = 0; m_bus = '0;
            end
        endcase
    endfunction

    task automatic check(input string name);
        logic [N-1:0] eg;
        int           eo;
        logic         eb;
        eg = (m_state == 1) ? (N'(1) << m_owner) : '0;
        eo = (m_state == 1) ? m_owner : 0;
        eb = (m_state != 0);
        n_vec++;
        if (gnt !== eg || owner !== 3'(eo) || busy !== eb ||
            bus_dat !== m_bus || tmo !== m_tmo) begin
            n_err++;
            $display("FAIL %s: got gnt=%b owner=%0d busy=%b bus_dat=%h tmo=%b, want gnt=%b owner=%0d busy=%b bus_dat=%h tmo=%b",
                     name, gnt, owner, busy, bus_dat, tmo, eg, eo, eb, m_bus, m_tmo);
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] q,
                        input logic [N-1:0] l, input string name);
        rst = r; req = q; rel = l;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(name);
    endtask

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic [3:0] l;
        logic [3:0] eg;
        int         eo;
        logic       eb;
    } vec_t;

    vec_t tbl[18];

    initial begin
        rst = 1'b1; req = '0; rel = '0; wdat = 32'hDDCC_BBAA;
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2, 1'b1};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2, 1'b1};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[5]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1, 1'b1};
        tbl[6]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0011, 4'b0000, 4'b0001, 0, 1'b1};
        tbl[8]  = '{1'b0, 4'b0011, 4'b0001, 4'b0000, 0, 1'b1};
        tbl[9]  = '{1'b0, 4'b0011, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[10] = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 1, 1'b1};
        tbl[11] = '{1'b0, 4'b1010, 4'b1000, 4'b0010, 1, 1'b1};
        tbl[12] = '{1'b0, 4'b0010, 4'b1000, 4'b0010, 1, 1'b1};
        tbl[13] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 0, 1'b1};
        tbl[14] = '{1'b0, 4'b1000, 4'b0000, 4'b0000, 0, 1'b0};
        tbl[15] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 3, 1'b1};
        tbl[16] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 0, 1'b1};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].r, tbl[i].q, tbl[i].l, $sformatf("model_row%0d", i));
            n_vec++;
            if (gnt !== tbl[i].eg || owner !== 3'(tbl[i].eo) || busy !== tbl[i].eb) begin
                n_err++;
                $display("FAIL table_row%0d: got gnt=%b owner=%0d busy=%b want gnt=%b owner=%0d busy=%b",
                         i, gnt, owner, busy, tbl[i].eg, tbl[i].eo, tbl[i].eb);
            end
            if (i == 1) cmp("bus_dat_owner2", int'(bus_dat), 32'hCC);
        end

        // Full contention with two-cycle grants and rel-driven release.
        step(1'b1, 4'b0000, 4'b0000, "rr_reset");
        for (int g = 0; g < 5; g++) begin
            step(1'b0, 4'b1111, 4'b0000, "rr_grant1");
            cmp("rr_order", int'(owner), g % N);
            step(1'b0, 4'b1111, 4'b0000, "rr_grant2");
            step(1'b0, 4'b1111, 4'(1 << (g % N)), "rr_release");
            cmp("rr_recover_gnt", int'(gnt), 0);
            cmp("rr_recover_busy", int'(busy), 1);
            step(1'b0, 4'b1111, 4'b0000, "rr_idle");
        end

`ifdef BUS_RR_ARBITER_TIMEOUT_EN
        step(1'b1, 4'b0000, 4'b0000, "to_reset");
        for (int c = 0; c < HM + 1; c++) begin
            step(1'b0, 4'b0001, 4'b0000, "to_hold");
            cmp("to_hold_gnt", int'(gnt), 1);
        end
        step(1'b0, 4'b0001, 4'b0000, "to_recover");
        cmp("to_tmo_pulse", int'(tmo), 1);
        step(1'b0, 4'b0001, 4'b0000, "to_idle");
        cmp("to_tmo_clear", int'(tmo), 0);
        step(1'b0, 4'b0001, 4'b0000, "to_regrant");
        cmp("to_regrant_gnt", int'(gnt), 1);
        for (int c = 0; c < HM; c++) begin
            step(1'b0, 4'b0001, 4'b0000, "to_hold2");
        end
        step(1'b0, 4'b0001, 4'b0001, "to_rel_coincide");
        cmp("to_rel_tmo", int'(tmo), 0);
        cmp("to_rel_busy", int'(busy), 1);
`else
        step(1'b1, 4'b0000, 4'b0000, "hold_reset");
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 4'b0001, 4'b0000, "hold_long");
            cmp("hold_long_gnt", int'(gnt), 1);
            cmp("hold_long_tmo", int'(tmo), 0);
        end
`endif

        for (int c = 0; c < 600; c++) begin
            wdat = $urandom;
            step(($urandom_range(0, 49) == 0), 4'($urandom),
                 4'($urandom & $urandom), "random");
            if ((gnt & (gnt - 1'b1)) != '0) begin
                n_vec++;
                n_err++;
                $display("FAIL random_onehot: got gnt=%b want at most one bit", gnt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the bus; legal range 2..8.
REQ-002 Parameter W, default 8: width of the shared data bus.
REQ-003 Parameter HOLD_MAX, default 15: maximum grant length in cycles; legal range 1..255.
REQ-004 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port req, input, N: per-requester bus request, level-sensitive.
REQ-007 Port rel, input, N: per-requester release strobe; only rel[owner] is meaningful.
REQ-008 Port wdat, input, N*W: packed write data; slice i, bits [i*W +: W], belongs to requester i.
REQ-009 Port gnt, output, N: one-hot grant, or all-zero.
REQ-010 Port owner, output, 3: index of the granted requester; 0 when no grant.
REQ-011 Port busy, output, 1: high in GRANT and RECOVER.
REQ-012 Port bus_dat, output, W: wdat slice of the owner while in GRANT; all-zero otherwise.
REQ-013 Port tmo, output, 1: single-cycle pulse marking a forced release.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, GRANT and RECOVER.
- IDLE: gnt=0, busy=0.
- GRANT: gnt=onehot(owner), busy=1.
- RECOVER: gnt=0, busy=1, lasting exactly one cycle.
REQ-015 IDLE with any req bit high at edge t SHALL enter GRANT at t+1.
- Owner is the first requester with req high, searching from ptr upward modulo N.
- Latency from req to gnt is one cycle.
REQ-016 On every entry to GRANT, ptr SHALL become (owner+1) mod N.
REQ-017 GRANT SHALL exit to RECOVER on the edge where rel[owner]=1 or req[owner]=0.
- rel and req of non-owners SHALL NOT affect GRANT.
REQ-018 RECOVER SHALL always go to IDLE on the next edge.
- A new grant therefore occurs no earlier than two cycles after release (bus turnaround).
REQ-019 The hold counter SHALL clear on entry to GRANT and increment each cycle in GRANT, saturating at HOLD_MAX.
REQ-020 gnt, owner and bus_dat SHALL be registered outputs, glitch-free, and SHALL NOT depend combinationally on req or rel.
REQ-021 No two gnt bits SHALL ever be high together; gnt SHALL be nonzero only in GRANT.
REQ-022 Requesters not granted SHALL be served in round-robin order: each waits at most N-1 grants while its req stays high.

Reset
REQ-023 rst=1 at an edge SHALL force all of the following from the next cycle, in any state, including mid-grant:
- state=IDLE, ptr=0, hold counter=0;
- gnt=0, owner=0, busy=0, bus_dat=0, tmo=0.
REQ-024 The first edge with rst=0 SHALL evaluate IDLE arbitration normally.

Configuration
REQ-025 Macro BUS_RR_ARBITER_TIMEOUT_EN SHALL compile the forced-release feature in or out.
REQ-026 With BUS_RR_ARBITER_TIMEOUT_EN defined:
- when the hold counter equals HOLD_MAX in GRANT, the next edge SHALL enter RECOVER even if req[owner] stays high;
- tmo SHALL be 1 for exactly the RECOVER cycle that follows.
REQ-027 If rel[owner] and timeout coincide on the same edge, it SHALL be treated as a normal release with tmo=0.
REQ-028 Without BUS_RR_ARBITER_TIMEOUT_EN:
- GRANT lasts until rel or req drops;
- tmo SHALL be tied to 0;
- the hold counter SHALL be removed from the design.

Verification
REQ-029 Reset, then req=4'b0100 at cycle 1 -> gnt=4'b0100, owner=2 at cycle 2; bus_dat=wdat[23:16].
REQ-030 req=4'b1111 held; each owner releases via rel after 2 cycles of grant -> grant order 0,1,2,3,0; one RECOVER cycle with gnt=0 between grants.
REQ-031 TIMEOUT_EN defined, HOLD_MAX=3, req=4'b0001 held, no rel -> gnt high 4 cycles, then tmo=1 for one cycle, gnt=0, busy=1; regrant 2 cycles later.
REQ-032 rst=1 asserted while gnt=4'b0010 -> next cycle gnt=0, owner=0, busy=0; after release of reset, req=4'b0011 -> requester 0 granted (ptr reset to 0).
REQ-033 Owner 1 granted, req[3] and rel[3] toggled during the grant -> no state change; drop req[1] -> RECOVER, then IDLE.
REQ-034 TIMEOUT_EN defined, rel[owner] asserted on the edge the hold counter reaches HOLD_MAX -> RECOVER entered with tmo=0.
